seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Upstream feeder for the 74HC595 serial driver on the digital-tube board. Holds a coherent snapshot of an 8-digit hex display value, time-multiplexes the digits, decodes each to 7-segment code plus decimal point, and presents one 16-bit word (segments + digit select) with a single-cycle `en` strobe per digit slot. The 595 driver shifts the word out MSB first, so the segment byte reaches the far register.

## Interface
- `SCAN_DIV`, default 50000. Clocks per digit slot, 1 ms at 50 MHz. Legal range 128..2^20-1; 128 covers one full 595 frame of 32 sck pulses at 4 clk each.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `disp_data`  in  32  eight hex nibbles; [3:0] = digit 0 (rightmost), [31:28] = digit 7.
- `dp_mask`  in  8  bit i = 1 lights the decimal point of digit i.
- `dig_en`  in  8  bit i = 0 blanks digit i.
- `data_out`  out  16  {seg[7:0], sel[7:0]}; feeds the driver's `data_in`.
- `en`  out  1  one-cycle strobe; `data_out` is valid in the same cycle.

## Operation
- Encoding: segments active-low (common anode). seg bit order {dp,g,f,e,d,c,b,a}. sel is one-hot active-low, bit i selects digit i.
- Hex decode with dp off, 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E. dp on clears seg[7].
- Blanked digit (dig_en[i]=0): word = {8'hFF, sel for i}. Select stays asserted, all segments off. This keeps slot timing uniform.
- Counters:
  - `div_cnt` counts 0..SCAN_DIV-1 and wraps.
  - `idx` (3 bits) is the current digit.
  - `tick` = (div_cnt == SCAN_DIV-1).
- On the edge where `tick` is true:
  - `div_cnt` <= 0.
  - `idx` <= idx+1, mod 8 (7 -> 0 wraps).
  - `data_out` <= word for the new idx.
  - `en` <= 1.
- On every other edge, `en` <= 0 and `data_out` holds.
- Snapshot: when idx wraps 7 -> 0, `disp_data`, `dp_mask` and `dig_en` load into shadow registers on that same edge.
  - The digit-0 word is built from the values being captured, not from the old shadow.
  - Digits 1..7 are built from the shadow.
  - Input changes mid-frame never take effect until the next frame. No mixed frames.
- No input handshake is needed; inputs may change on any cycle.

## Timing
- Reset values:
  - `data_out` = 16'hFFFF (all segments off, no digit selected).
  - `en` = 0.
  - `div_cnt` = 0.
  - `idx` = 7, so the first slot is digit 0 and triggers a snapshot.
  - Shadow registers = 0.
- First `en` comes on the SCAN_DIV-th rising edge after reset release, carrying digit 0.
- Later `en` pulses are exactly SCAN_DIV cycles apart. One full frame is 8*SCAN_DIV cycles.
- Latency from a `disp_data` change to display is at most 8*SCAN_DIV + 1 cycles. If the change is present on the wrap edge, latency is 0 slots.
- `en` is high for exactly 1 cycle. `data_out` is stable for SCAN_DIV-1 cycles after each strobe, which covers the driver's 128-cycle frame.
- Reset asserted mid-slot: all outputs return to reset values immediately (async). The sequence restarts from digit 0 with a fresh snapshot.
- SCAN_DIV below 128 is unsupported. The bench checks the parameter with an assertion.

## Test plan
Bench uses SCAN_DIV=200.
- Reset check: hold rst=0, then release. `data_out`=16'hFFFF and `en`=0 until cycle 200. At cycle 200, `en`=1 with a digit-0 word.
- Full decode: disp_data=32'h76543210, dp_mask=0, dig_en=FF. Eight strobes give data_out = C0FE, F9FD, A4FB, B0F7, 99EF, 92DF, 82BF, F87F. Repeat with 32'hFEDCBA98 and expect segment bytes 80 90 88 83 C6 A1 86 8E.
- Dp/blank: dp_mask=8'h04, dig_en=8'hFD on 32'h00000000. Digit 1 gives FFFD. Digit 2 gives 40FB. Other digits give C0 with their own sel.
- Coherency: change disp_data from 32'h11111111 to 32'h22222222 while idx=3. Digits 4..7 still show F9. The next digit 0 shows A4.
- Strobe spacing: over 3 frames, every `en` is a single cycle, pulses are 200 cycles apart, and idx follows 0..7 with wrap.
- Async reset mid-slot: pull rst low at cycle 950. `data_out` goes to FFFF and `en` to 0 with no clock edge needed. After release, the first strobe comes 200 cycles later with digit 0.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - display value inputs and driver word output of seg_scan_ctrl
interface seg_scan_ctrl_if;
    logic [31:0] disp_data;
    logic [7:0]  dp_mask;
    logic [7:0]  dig_en;
    logic [15:0] data_out;
    logic        en;

    modport master (
        output disp_data, dp_mask, dig_en,
        input  data_out, en
    );

    modport slave (
        input  disp_data, dp_mask, dig_en,
        output data_out, en
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 8-digit hex 7-segment scanner producing strobed 595 words
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_ctrl_if.slave bus
);
    localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);

    logic [19:0] div_cnt;
    logic [2:0]  idx;
    logic [31:0] sh_data;
    logic [7:0]  sh_dp;
    logic [7:0]  sh_en;

    logic        tick;
    logic        wrap;
    logic [2:0]  idx_nxt;
    logic [31:0] src_data;
    logic [7:0]  src_dp;
    logic [7:0]  src_en;
    logic [3:0]  nib;
    logic [7:0]  seg;
    logic [7:0]  sel;
    logic [15:0] word;

    function automatic logic [7:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 8'hC0;
            4'h1: hex7 = 8'hF9;
            4'h2: hex7 = 8'hA4;
            4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;
            4'h5: hex7 = 8'h92;
            4'h6: hex7 = 8'h82;
            4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;
            4'h9: hex7 = 8'h90;
            4'hA: hex7 = 8'h88;
            4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;
            4'hD: hex7 = 8'hA1;
            4'hE: hex7 = 8'h86;
            default: hex7 = 8'h8E;
        endcase
    endfunction

    assign tick    = (div_cnt == DIV_LAST);
    assign wrap    = (idx == 3'd7);
    assign idx_nxt = idx + 3'd1;

    // On the wrap edge digit 0 must come from the values being captured, not the stale shadow
    always_comb begin
        src_data = sh_data;
        src_dp   = sh_dp;
        src_en   = sh_en;
        if (wrap) begin
            src_data = bus.disp_data;
            src_dp   = bus.dp_mask;
            src_en   = bus.dig_en;
        end
        nib  = src_data[{idx_nxt, 2'b00} +: 4];
        seg  = 8'hFF;
        if (src_en[idx_nxt])
            seg = hex7(nib) & ~{src_dp[idx_nxt], 7'b000_0000};
        sel  = ~(8'b0000_0001 << idx_nxt);
        word = {seg, sel};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt      <= '0;
            idx          <= 3'd7;
            sh_data      <= '0;
            sh_dp        <= '0;
            sh_en        <= '0;
            bus.data_out <= 16'hFFFF;
            bus.en       <= 1'b0;
        end else begin
            bus.en <= 1'b0;
            if (tick) begin
                div_cnt      <= '0;
                idx          <= idx_nxt;
                bus.data_out <= word;
                bus.en       <= 1'b1;
                if (wrap) begin
                    sh_data <= bus.disp_data;
                    sh_dp   <= bus.dp_mask;
                    sh_en   <= bus.dig_en;
                end
            end else begin
                div_cnt <= div_cnt + 20'd1;
            end
        end
    end
endmodule
